// File: rtl/seven_segment_digit_monitor.sv
// Seven-segment receive monitor: synchronizes, deglitches and decodes a
// segment bus, then checks digit sequencing and measures the update period.
module seven_segment_digit_monitor #(
  parameter int STABLE_CYCLES = 16,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  output logic                new_digit,
  output logic                seq_error,
  output logic                bad_pattern,
  output logic [7:0]          err_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam logic [7:0] SC    = 8'(STABLE_CYCLES);
  localparam logic [7:0] SC_M1 = 8'(STABLE_CYCLES - 1);

  logic [6:0]          r_s1;
  logic [6:0]          r_s2;
  logic [6:0]          r_cand;
  logic [6:0]          r_last;
  logic [7:0]          r_stab;
  logic                r_have_prev;
  logic [PERIOD_W-1:0] r_pcnt;

  logic                w_legal;
  logic [3:0]          w_dec;
  logic [3:0]          w_next;
  logic                w_accept;
  logic                w_seq_bad;
  logic                w_p_sat;
  logic                w_e_sat;

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 4'd0;
    case (r_cand)
      7'h3F: w_dec = 4'd0;
      7'h06: w_dec = 4'd1;
      7'h5B: w_dec = 4'd2;
      7'h4F: w_dec = 4'd3;
      7'h66: w_dec = 4'd4;
      7'h6D: w_dec = 4'd5;
      7'h7C: w_dec = 4'd6;
      7'h7D: w_dec = 4'd6;
      7'h07: w_dec = 4'd7;
      7'h7F: w_dec = 4'd8;
      7'h67: w_dec = 4'd9;
      7'h6F: w_dec = 4'd9;
      default: w_legal = 1'b0;
    endcase
  end

  // Accept fires once per stable run; re-showing the last pattern is silent.
  assign w_accept  = (r_s2 == r_cand) &&
                     (r_stab == SC_M1) &&
                     (r_cand != r_last);
  assign w_next    = (digit_out == 4'd9) ? 4'd0 : digit_out + 4'd1;
  assign w_seq_bad = r_have_prev && (w_dec != w_next);
  assign w_p_sat   = &r_pcnt;
  assign w_e_sat   = &err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_cand       <= '0;
      r_last       <= '0;
      r_stab       <= '0;
      r_have_prev  <= 1'b0;
      r_pcnt       <= '0;
      digit_out    <= '0;
      digit_valid  <= 1'b0;
      new_digit    <= 1'b0;
      seq_error    <= 1'b0;
      bad_pattern  <= 1'b0;
      err_count    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      r_s1        <= seg_in;
      r_s2        <= r_s1;
      new_digit   <= 1'b0;
      seq_error   <= 1'b0;
      bad_pattern <= 1'b0;

      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_stab <= '0;
      end else if (r_stab == SC_M1) begin
        r_stab <= SC;
      end else if (r_stab < SC) begin
        r_stab <= r_stab + 8'd1;
      end

      if (!w_p_sat)
        r_pcnt <= r_pcnt + 1'b1;

      if (w_accept) begin
        r_last <= r_cand;
        if (w_legal) begin
          digit_out   <= w_dec;
          digit_valid <= 1'b1;
          new_digit   <= 1'b1;
          r_pcnt      <= '0;
          r_have_prev <= 1'b1;
          if (r_have_prev) begin
            period       <= w_p_sat ? r_pcnt : r_pcnt + 1'b1;
            period_valid <= 1'b1;
            seq_error    <= w_seq_bad;
          end
        end else begin
          bad_pattern <= 1'b1;
          digit_valid <= 1'b0;
          r_have_prev <= 1'b0;
        end
        if ((!w_legal || w_seq_bad) && !w_e_sat)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_digit_monitor.sv
// Bench for seven_segment_digit_monitor: directed scenarios plus random
// segment traffic compared cycle by cycle against a behavioural model.
module tb_seven_segment_digit_monitor;

  localparam int SC   = 4;
  localparam int PW   = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    seg_in = 7'h00;
  logic [3:0]    digit_out;
  logic          digit_valid;
  logic          new_digit;
  logic          seq_error;
  logic          bad_pattern;
  logic [7:0]    err_count;
  logic [PW-1:0] period;
  logic          period_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_segment_digit_monitor #(
    .STABLE_CYCLES(SC),
    .PERIOD_W     (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .new_digit   (new_digit),
    .seq_error   (seq_error),
    .bad_pattern (bad_pattern),
    .err_count   (err_count),
    .period      (period),
    .period_valid(period_valid)
  );

  // Reference model: a pattern is taken once seg_in has been sampled
  // SC+1 times in a row; outputs show it two edges later.
  int         dec_tab [128];
  logic [6:0] pat_of  [10];
  int         m_digit, m_err, m_period, m_pcnt, run_len;
  bit         m_dv, m_nd, m_seq, m_bad, m_pv, m_hp;
  bit         ev1, ev2;
  logic [6:0] ev1_p, ev2_p, run_val, m_last;

  always @(posedge clk) begin : model
    bit         e;
    logic [6:0] p;
    int         d;
    if (reset) begin
      m_digit = 0; m_err = 0; m_period = 0; m_pcnt = 0;
      m_dv = 0; m_nd = 0; m_seq = 0; m_bad = 0; m_pv = 0; m_hp = 0;
      m_last = 7'h00; run_val = 7'h00; run_len = 1000;
      ev1 = 0; ev2 = 0;
    end else begin
      e = ev2; p = ev2_p;
      ev2 = ev1; ev2_p = ev1_p;
      if (seg_in == run_val) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_val = seg_in; run_len = 1;
      end
      ev1 = (run_len == SC + 1); ev1_p = run_val;
      m_nd = 0; m_seq = 0; m_bad = 0;
      if (e && p != m_last) begin
        m_last = p;
        d = dec_tab[p];
        if (d >= 0) begin
          if (m_hp && d != (m_digit + 1) % 10) begin
            m_seq = 1;
            if (m_err < 255) m_err++;
          end
          if (m_hp) begin
            m_period = (m_pcnt + 1 > PMAX) ? PMAX : m_pcnt + 1;
            m_pv = 1;
          end
          m_digit = d; m_dv = 1; m_nd = 1; m_pcnt = 0; m_hp = 1;
        end else begin
          m_bad = 1; m_dv = 0; m_hp = 0;
          if (m_err < 255) m_err++;
          if (m_pcnt < PMAX) m_pcnt++;
        end
      end else if (m_pcnt < PMAX) begin
        m_pcnt++;
      end
    end
  end

  wire [24:0] w_dut = {digit_out, digit_valid, new_digit, seq_error,
                       bad_pattern, err_count, period, period_valid};
  wire [24:0] w_exp = {4'(m_digit), m_dv, m_nd, m_seq, m_bad,
                       8'(m_err), 8'(m_period), m_pv};

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int lat = -1;
    seg_in = 7'h3F;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (w_dut !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", w_dut);
    end
    reset = 1'b0;
    for (int k = 1; k <= SC + 8; k++) begin
      @(negedge clk);
      total++;
      if (w_dut !== w_exp) begin
        bad++;
        $display("FAIL reset_model k=%0d got=%h want=%h", k, w_dut, w_exp);
      end
      if (new_digit && lat < 0) lat = k;
    end
    total++;
    if (lat != SC + 3) begin
      bad++;
      $display("FAIL reset_latency got=%0d want=%0d", lat, SC + 3);
    end
    total++;
    if ({digit_out, period_valid} !== 5'd0) begin
      bad++;
      $display("FAIL reset_first got=%h/%b want=0/0", digit_out, period_valid);
    end
  endtask

  task automatic test_sequence();
    int pulses = 0, seqs = 0;
    seg_in = 7'h3F;
    pulse_reset();
    for (int i = 0; i <= 10; i++) begin
      seg_in = pat_of[i % 10];
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        total++;
        if (w_dut !== w_exp) begin
          bad++;
          $display("FAIL seq_model i=%0d got=%h want=%h", i, w_dut, w_exp);
        end
        if (seq_error) seqs++;
        if (new_digit) begin
          pulses++;
          if (pulses >= 2) begin
            total++;
            if (period !== 8'd100) begin
              bad++;
              $display("FAIL seq_period got=%0d want=100", period);
            end
          end
        end
      end
    end
    total++;
    if (pulses != 11 || seqs != 0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL seq_counts got=%0d/%0d/%0d want=11/0/0",
               pulses, seqs, err_count);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    seg_in = 7'h4F;
    pulse_reset();
    repeat (20) @(negedge clk);
    total++;
    if (digit_out !== 4'd3) begin
      bad++;
      $display("FAIL glitch_pre got=%0d want=3", digit_out);
    end
    seg_in = 7'h66;
    for (int c = 0; c < 23; c++) begin
      if (c == 3) seg_in = 7'h4F;
      @(negedge clk);
      total++;
      if (w_dut !== w_exp) begin
        bad++;
        $display("FAIL glitch_model c=%0d got=%h want=%h", c, w_dut, w_exp);
      end
      if (new_digit || bad_pattern) pulses++;
    end
    total++;
    if (pulses != 0 || digit_out !== 4'd3) begin
      bad++;
      $display("FAIL glitch_hold got=%0d/%0d want=0/3", pulses, digit_out);
    end
  endtask

  task automatic test_seq_error();
    logic [6:0] p [3] = '{7'h3F, 7'h06, 7'h4F};
    int seqs = 0;
    seg_in = p[0];
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      seg_in = p[i];
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        total++;
        if (w_dut !== w_exp) begin
          bad++;
          $display("FAIL seqerr_model i=%0d got=%h want=%h", i, w_dut, w_exp);
        end
        if (seq_error) seqs++;
      end
    end
    total++;
    if (seqs != 1 || err_count !== 8'd1 || digit_out !== 4'd3) begin
      bad++;
      $display("FAIL seqerr_result got=%0d/%0d/%0d want=1/1/3",
               seqs, err_count, digit_out);
    end
  endtask

  task automatic test_bad_pattern();
    int bads = 0, seqs = 0;
    seg_in = 7'h06;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      seg_in = (i == 0) ? 7'h06 : (i == 1) ? 7'h00 : 7'h5B;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        total++;
        if (w_dut !== w_exp) begin
          bad++;
          $display("FAIL badpat_model i=%0d got=%h want=%h", i, w_dut, w_exp);
        end
        if (bad_pattern) bads++;
        if (seq_error) seqs++;
      end
      if (i == 1) begin
        total++;
        if (bads != 1 || digit_valid !== 1'b0 || err_count !== 8'd1 ||
            digit_out !== 4'd1) begin
          bad++;
          $display("FAIL badpat_00 got=%0d/%b/%0d/%0d want=1/0/1/1",
                   bads, digit_valid, err_count, digit_out);
        end
      end
    end
    total++;
    if (digit_out !== 4'd2 || digit_valid !== 1'b1 || seqs != 0 ||
        period_valid !== 1'b0 || period !== 8'd0) begin
      bad++;
      $display("FAIL badpat_5B got=%0d/%b/%0d/%b/%0d want=2/1/0/0/0",
               digit_out, digit_valid, seqs, period_valid, period);
    end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    seg_in = 7'h01;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      seg_in = (i % 2 == 0) ? 7'h01 : 7'h02;
      repeat (10) @(negedge clk);
    end
    total++;
    if (err_count !== 8'd5) begin
      bad++;
      $display("FAIL rmid_pre got=%0d want=5", err_count);
    end
    seg_in = 7'h3F;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (err_count !== 8'd0 || period_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_clear got=%0d/%b want=0/0", err_count, period_valid);
    end
    for (int k = 1; k <= SC + 8; k++) begin
      @(negedge clk);
      if (new_digit && lat < 0) lat = k;
    end
    total++;
    if (lat != SC + 3 || digit_out !== 4'd0) begin
      bad++;
      $display("FAIL rmid_reaccept got=%0d/%0d want=%0d/0",
               lat, digit_out, SC + 3);
    end
  endtask

  task automatic test_period_sat();
    seg_in = 7'h3F;
    pulse_reset();
    repeat (20) @(negedge clk);
    seg_in = 7'h06;
    repeat (300) @(negedge clk);
    total++;
    if (period !== 8'd20 || period_valid !== 1'b1) begin
      bad++;
      $display("FAIL psat_short got=%0d want=20", period);
    end
    seg_in = 7'h5B;
    repeat (20) @(negedge clk);
    total++;
    if (period !== 8'(PMAX) || w_dut !== w_exp) begin
      bad++;
      $display("FAIL psat_long got=%0d want=%0d", period, PMAX);
    end
  endtask

  task automatic test_err_sat();
    seg_in = 7'h01;
    pulse_reset();
    for (int i = 0; i < 262; i++) begin
      seg_in = (i % 2 == 0) ? 7'h02 : 7'h01;
      repeat (6) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    total++;
    if (err_count !== 8'hFF || w_dut !== w_exp) begin
      bad++;
      $display("FAIL esat got=%0d want=255", err_count);
    end
  endtask

  task automatic test_random();
    int mode, len, nd;
    seg_in = 7'h3F;
    pulse_reset();
    for (int s = 0; s < 160; s++) begin
      mode = int'($urandom_range(0, 11));
      nd   = (m_digit + 1) % 10;
      if (mode <= 5)
        seg_in = (nd == 6 && mode[0]) ? 7'h7C :
                 (nd == 9 && mode[0]) ? 7'h67 : pat_of[nd];
      else if (mode <= 7)
        seg_in = pat_of[$urandom_range(0, 9)];
      else
        seg_in = 7'($urandom);
      len = (mode == 11) ? int'($urandom_range(1, SC))
                         : int'($urandom_range(1, 40));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        total++;
        if (w_dut !== w_exp) begin
          bad++;
          $display("FAIL rand_model s=%0d got=%h want=%h", s, w_dut, w_exp);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) dec_tab[i] = -1;
    dec_tab[7'h3F] = 0; dec_tab[7'h06] = 1; dec_tab[7'h5B] = 2;
    dec_tab[7'h4F] = 3; dec_tab[7'h66] = 4; dec_tab[7'h6D] = 5;
    dec_tab[7'h7C] = 6; dec_tab[7'h7D] = 6; dec_tab[7'h07] = 7;
    dec_tab[7'h7F] = 8; dec_tab[7'h67] = 9; dec_tab[7'h6F] = 9;
    pat_of = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    test_reset();
    test_sequence();
    test_glitch();
    test_seq_error();
    test_bad_pattern();
    test_reset_mid();
    test_period_sat();
    test_err_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
